mac_accumulator: RTL and testbench
==================================

// Module: mac_accumulator
// PURPOSE
//  Accumulate stage of the MAC, directly downstream of the sequential multiplier.
//  Captures one product per rising edge of the multiplier's result-valid flag.
//  Sums TERMS products, then presents the saturated sum on a valid/ready output and restarts.
//  A one-entry pending register absorbs a product that arrives while the sum waits for acceptance.
// PARAMETERS
//  PROD_WIDTH  10  width of incoming product (matches 5x5 multiplier result)
//  ACC_WIDTH   16  accumulator / sum width; must be >= PROD_WIDTH
//  TERMS       4   products per emitted sum; must be >= 2
//  CNT_WIDTH   derived localparam = $clog2(TERMS+1)
// PORTS
//  acc_clk_i        in   1           clock, all state updates on rising edge
//  acc_reset_i      in   1           synchronous, active-high reset
//  product_i        in   PROD_WIDTH  unsigned product from multiplier result output
//  product_valid_i  in   1           multiplier result-valid; may stay high for many cycles
//  clear_i          in   1           synchronous soft clear
//  sum_ready_i      in   1           consumer accepts sum_o
//  sum_o            out  ACC_WIDTH   completed sum, held stable while sum_valid_o=1
//  sum_valid_o      out  1           sum_o valid
//  term_count_o     out  CNT_WIDTH   products in the current partial sum
//  overflow_o       out  1           sticky: accumulation saturated
//  overrun_o        out  1           sticky: product dropped (pending register already full)
// BEHAVIOUR
//  - Reset: all outputs 0, acc=0, pending empty, edge history=0, state ACCUM.
//    A product_valid_i already high when reset releases counts as one edge.
//  - Priority: acc_reset_i > clear_i > normal operation. clear_i has the same effect as reset.
//  - Accept event: product_valid_i=1 while the registered copy=0. Level-high never re-accepts.
//  - ACCUM state, on an accept edge:
//    - count<TERMS-1: acc<=sat(acc+product_i); count++.
//    - count=TERMS-1: sum_o<=sat(acc+product_i); sum_valid_o<=1; acc<=0; count<=0; go to HOLD.
//    - Result is visible the cycle after the edge (latency 1).
//  - HOLD state: sum_o/sum_valid_o stay frozen until sum_ready_i=1 is sampled.
//    - Accept edge, pending empty -> store product in pending.
//    - Accept edge, pending full -> drop product; overrun_o<=1.
//  - HOLD exit (sum_ready_i=1 sampled): sum_valid_o<=0; go to ACCUM.
//    - Pending is folded into acc: acc<=pending; count<=1; pending cleared.
//    - Same-cycle accept edge, pending full: acc<=pending+product; count<=2.
//    - Same-cycle accept edge, pending empty: acc<=product; count<=1.
//  - sum_ready_i is ignored in ACCUM.
//  - Arithmetic: unsigned. Product zero-extended to ACC_WIDTH.
//    - On carry-out, result = all-ones and overflow_o<=1 (sticky until reset/clear).
//  - term_count_o mirrors count; it is 0 in HOLD unless pending is counted after exit.
// STRUCTURE
//  - mac_pkg: state encoding (ACCUM=1'b0, HOLD=1'b1) and default width constants
//    (MAC_OP_WIDTH=5, MAC_PROD_WIDTH=10), shared with the multiplier.
//  - Sub-module valid_edge_detect (registered rising-edge detector, sync reset) for product_valid_i.
//  - Remainder: FSM, saturating adder, pending register, counters in this file.
// TESTING
//  1. Reset, then 4 accept edges of 961 (31*31)
//     -> sum_o=3844, sum_valid_o=1 the cycle after the 4th edge; held until sum_ready_i.
//  2. product_valid_i high for 5 cycles, product 210 -> term_count_o=1, acc=210 (single accept).
//  3. In HOLD, one edge of 210, ready asserted 3 cycles later
//     -> sum_valid_o=0, term_count_o=1; next sum includes 210.
//  4. In HOLD, edges of 210 then 100 -> overrun_o=1; after ready acc=210; 100 lost.
//  5. ACC_WIDTH=11, 3 edges of 961 -> acc=2047, overflow_o=1; clear_i -> all outputs 0.
//  6. acc_reset_i after 2 terms mid-accumulation
//     -> next cycle term_count_o=0, sum_valid_o=0, flags 0; a fresh 4-term run sums correctly.

Source files
------------

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC datapath (multiplier + accumulator).
//   mac_state_t     accumulator FSM encoding (ACCUM / HOLD)
//   MAC_OP_WIDTH    default multiplier operand width
//   MAC_PROD_WIDTH  default multiplier product width (2 * MAC_OP_WIDTH)
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } mac_state_t;

    localparam int MAC_OP_WIDTH   = 5;
    localparam int MAC_PROD_WIDTH = 10;

endpackage

// File: rtl/valid_edge_detect.sv
// ---------------------------------------------------------------------------
// valid_edge_detect
// Rising-edge detector for a level valid flag. The previous level is kept
// in a register; an edge is reported combinationally whenever the flag is
// high and the registered copy is low. Reset zeroes the history, so a flag
// that is already high when reset releases is reported as one edge.
// Ports:
//   clk_i    in   clock
//   reset_i  in   synchronous active-high reset
//   valid_i  in   level valid flag being watched
//   edge_o   out  1 for the cycle in which valid_i rises
// ---------------------------------------------------------------------------
module valid_edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic valid_i,
    output logic edge_o
);

    logic r_valid_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= valid_i;
        end
    end

    assign edge_o = valid_i & ~r_valid_q;

endmodule

// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
// Accumulate stage of the MAC. Adds TERMS unsigned products (one per rising
// edge of product_valid_i) with saturation, then presents the sum on a
// valid/ready output. While the sum waits, a one-entry pending register
// keeps the next product; further products are dropped and flagged.
// Ports:
//   acc_clk_i        in   clock
//   acc_reset_i      in   synchronous active-high reset
//   product_i        in   unsigned product from the multiplier
//   product_valid_i  in   multiplier result-valid (level, may stay high)
//   clear_i          in   synchronous soft clear (same effect as reset)
//   sum_ready_i      in   consumer accepts sum_o
//   sum_o            out  completed saturated sum, stable while sum_valid_o
//   sum_valid_o      out  sum_o valid
//   term_count_o     out  products in the current partial sum
//   overflow_o       out  sticky: an addition saturated
//   overrun_o        out  sticky: a product was dropped in HOLD
// ---------------------------------------------------------------------------
module mac_accumulator
    import mac_pkg::*;
#(
    parameter  int PROD_WIDTH = MAC_PROD_WIDTH,
    parameter  int ACC_WIDTH  = 16,
    parameter  int TERMS      = 4,
    localparam int CNT_WIDTH  = $clog2(TERMS + 1)
) (
    input  logic                  acc_clk_i,
    input  logic                  acc_reset_i,
    input  logic [PROD_WIDTH-1:0] product_i,
    input  logic                  product_valid_i,
    input  logic                  clear_i,
    input  logic                  sum_ready_i,
    output logic [ACC_WIDTH-1:0]  sum_o,
    output logic                  sum_valid_o,
    output logic [CNT_WIDTH-1:0]  term_count_o,
    output logic                  overflow_o,
    output logic                  overrun_o
);

    mac_state_t            r_state;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [PROD_WIDTH-1:0] r_pend;
    logic                  r_pend_valid;
    logic [ACC_WIDTH-1:0]  r_sum;
    logic                  r_sum_valid;
    logic                  r_overflow;
    logic                  r_overrun;

    logic                  w_soft_reset;
    logic                  w_accept;
    logic [ACC_WIDTH-1:0]  w_prod_ext;
    logic [ACC_WIDTH-1:0]  w_pend_ext;
    logic [ACC_WIDTH:0]    w_acc_sum;
    logic [ACC_WIDTH:0]    w_fold_sum;
    logic [ACC_WIDTH-1:0]  w_acc_sat;
    logic [ACC_WIDTH-1:0]  w_fold_sat;

    // Clear behaves exactly like reset, including the edge history.
    assign w_soft_reset = acc_reset_i | clear_i;

    valid_edge_detect u_valid_edge (
        .clk_i   (acc_clk_i),
        .reset_i (w_soft_reset),
        .valid_i (product_valid_i),
        .edge_o  (w_accept)
    );

    assign w_prod_ext = ACC_WIDTH'(product_i);
    assign w_pend_ext = ACC_WIDTH'(r_pend);

    // One extra bit holds the carry; a set carry saturates to all-ones.
    assign w_acc_sum  = {1'b0, r_acc} + {1'b0, w_prod_ext};
    assign w_fold_sum = {1'b0, w_pend_ext} + {1'b0, w_prod_ext};
    assign w_acc_sat  = w_acc_sum[ACC_WIDTH]  ? '1 : w_acc_sum[ACC_WIDTH-1:0];
    assign w_fold_sat = w_fold_sum[ACC_WIDTH] ? '1 : w_fold_sum[ACC_WIDTH-1:0];

    // NOTE: all state below is written with non-blocking assignments so every
    // register sees the pre-edge values of the others, independent of order.
    always_ff @(posedge acc_clk_i) begin
        if (w_soft_reset) begin
            r_state      <= ST_ACCUM;
            r_acc        <= '0;
            r_count      <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_sum        <= '0;
            r_sum_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (r_count == CNT_WIDTH'(TERMS - 1)) begin
                            r_sum       <= w_acc_sat;
                            r_sum_valid <= 1'b1;
                            r_acc       <= '0;
                            r_count     <= '0;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_acc   <= w_acc_sat;
                            r_count <= r_count + CNT_WIDTH'(1);
                        end
                        if (w_acc_sum[ACC_WIDTH]) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (sum_ready_i) begin
                        // Leave HOLD and seed the next sum with whatever
                        // arrived meanwhile (pending and/or this cycle's edge).
                        r_sum_valid  <= 1'b0;
                        r_state      <= ST_ACCUM;
                        r_pend_valid <= 1'b0;
                        if (w_accept && r_pend_valid) begin
                            if (TERMS == 2) begin
                                // Two products already make a full sum.
                                r_sum       <= w_fold_sat;
                                r_sum_valid <= 1'b1;
                                r_state     <= ST_HOLD;
                            end else begin
                                r_acc   <= w_fold_sat;
                                r_count <= CNT_WIDTH'(2);
                            end
                            if (w_fold_sum[ACC_WIDTH]) begin
                                r_overflow <= 1'b1;
                            end
                        end else if (w_accept) begin
                            r_acc   <= w_prod_ext;
                            r_count <= CNT_WIDTH'(1);
                        end else if (r_pend_valid) begin
                            r_acc   <= w_pend_ext;
                            r_count <= CNT_WIDTH'(1);
                        end
                    end else if (w_accept) begin
                        if (r_pend_valid) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_pend       <= product_i;
                            r_pend_valid <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign sum_o        = r_sum;
    assign sum_valid_o  = r_sum_valid;
    assign term_count_o = r_count;
    assign overflow_o   = r_overflow;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator
// Self-checking bench for mac_accumulator. Instance A (16-bit accumulator)
// runs a vector table plus hand-written HOLD / pending / reset sequences;
// completed sums are checked by a scoreboard queue. Instance B (11-bit
// accumulator) covers saturation and soft clear.
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

    logic        clk;

    logic        a_reset, a_valid, a_clear, a_ready;
    logic [9:0]  a_product;
    logic [15:0] a_sum;
    logic        a_sv, a_ovf, a_ovr;
    logic [2:0]  a_cnt;

    logic        b_reset, b_valid, b_clear, b_ready;
    logic [9:0]  b_product;
    logic [10:0] b_sum;
    logic        b_sv, b_ovf, b_ovr;
    logic [2:0]  b_cnt;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q[$];
    logic        mon_prev;

    typedef struct {
        logic [9:0]  product;
        logic        valid;
        logic        ready;
        logic [2:0]  exp_cnt;
        logic        exp_sv;
        logic        push;
        logic [15:0] exp_sum;
    } vec_t;

    vec_t vecs[$];

    mac_accumulator #(.PROD_WIDTH(10), .ACC_WIDTH(16), .TERMS(4)) u_dut_a (
        .acc_clk_i       (clk),
        .acc_reset_i     (a_reset),
        .product_i       (a_product),
        .product_valid_i (a_valid),
        .clear_i         (a_clear),
        .sum_ready_i     (a_ready),
        .sum_o           (a_sum),
        .sum_valid_o     (a_sv),
        .term_count_o    (a_cnt),
        .overflow_o      (a_ovf),
        .overrun_o       (a_ovr)
    );

    mac_accumulator #(.PROD_WIDTH(10), .ACC_WIDTH(11), .TERMS(4)) u_dut_b (
        .acc_clk_i       (clk),
        .acc_reset_i     (b_reset),
        .product_i       (b_product),
        .product_valid_i (b_valid),
        .clear_i         (b_clear),
        .sum_ready_i     (b_ready),
        .sum_o           (b_sum),
        .sum_valid_o     (b_sv),
        .term_count_o    (b_cnt),
        .overflow_o      (b_ovf),
        .overrun_o       (b_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: each new sum_valid rise pops one expected sum.
    always @(negedge clk) begin
        if (a_sv && !mon_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got sum %0d expected no sum", a_sum);
            end else begin
                check("sb_sum", a_sum, exp_q.pop_front());
            end
        end
        mon_prev <= a_sv;
    end

    // Drive one cycle on instance A, then check its registered outputs.
    task automatic step(input logic [9:0] p, input logic v, input logic r,
                        input logic [2:0] ec, input logic esv, input logic eovf,
                        input logic eovr, input string name);
        a_product = p;
        a_valid   = v;
        a_ready   = r;
        @(posedge clk);
        #1;
        check({name, "_cnt"}, a_cnt, ec);
        check({name, "_sv"},  a_sv,  esv);
        check({name, "_ovf"}, a_ovf, eovf);
        check({name, "_ovr"}, a_ovr, eovr);
    endtask

    // One valid pulse (high one cycle, low one cycle), ready held low.
    task automatic pulse(input logic [9:0] p, input logic [2:0] ec, input logic esv,
                         input logic eovf, input logic eovr, input string name);
        step(p, 1'b1, 1'b0, ec, esv, eovf, eovr, name);
        step(p, 1'b0, 1'b0, ec, esv, eovf, eovr, name);
    endtask

    task automatic add(input logic [9:0] p, input logic v, input logic r,
                       input logic [2:0] ec, input logic esv, input logic push,
                       input logic [15:0] es);
        vec_t t;
        t.product = p; t.valid = v; t.ready = r;
        t.exp_cnt = ec; t.exp_sv = esv; t.push = push; t.exp_sum = es;
        vecs.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_prev = 1'b0;
        a_reset = 1'b1; a_valid = 1'b0; a_clear = 1'b0; a_ready = 1'b0; a_product = '0;
        b_reset = 1'b1; b_valid = 1'b0; b_clear = 1'b0; b_ready = 1'b0; b_product = '0;

        // Four edges of 961, held sum, then a level-high run of 210.
        add(961, 1, 0, 1, 0, 0, 0);
        add(961, 0, 0, 1, 0, 0, 0);
        add(961, 1, 0, 2, 0, 0, 0);
        add(0,   0, 0, 2, 0, 0, 0);
        add(961, 1, 0, 3, 0, 0, 0);
        add(0,   0, 0, 3, 0, 0, 0);
        add(961, 1, 0, 0, 1, 1, 3844);
        add(0,   0, 0, 0, 1, 0, 0);
        add(0,   0, 0, 0, 1, 0, 0);
        add(0,   0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(210, 1, 0, 1, 0, 0, 0);
        add(210, 0, 0, 1, 0, 0, 0);
        add(100, 1, 0, 2, 0, 0, 0);
        add(0,   0, 0, 2, 0, 0, 0);
        add(50,  1, 0, 3, 0, 0, 0);
        add(0,   0, 0, 3, 0, 0, 0);
        add(40,  1, 0, 0, 1, 1, 400);
        add(0,   0, 1, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        a_reset = 1'b0;
        b_reset = 1'b0;
        check("rst_cnt", a_cnt, 0);
        check("rst_sv",  a_sv,  0);
        check("rst_sum", a_sum, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_ovr", a_ovr, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].push) exp_q.push_back(vecs[i].exp_sum);
            step(vecs[i].product, vecs[i].valid, vecs[i].ready,
                 vecs[i].exp_cnt, vecs[i].exp_sv, 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        // One product in HOLD, ready three cycles later: it seeds the next sum.
        pulse(10, 1, 0, 0, 0, "t3_a");
        pulse(10, 2, 0, 0, 0, "t3_b");
        pulse(10, 3, 0, 0, 0, "t3_c");
        exp_q.push_back(40);
        pulse(10, 0, 1, 0, 0, "t3_d");
        pulse(210, 0, 1, 0, 0, "t3_hold_edge");
        step(0, 0, 0, 0, 1, 0, 0, "t3_wait");
        step(0, 0, 1, 1, 0, 0, 0, "t3_exit");
        pulse(1, 2, 0, 0, 0, "t3_e");
        pulse(2, 3, 0, 0, 0, "t3_f");
        exp_q.push_back(216);
        pulse(3, 0, 1, 0, 0, "t3_g");
        step(0, 0, 1, 0, 0, 0, 0, "t3_release");

        // Two products in HOLD: the second is dropped, overrun sticks.
        pulse(5, 1, 0, 0, 0, "t4_a");
        pulse(5, 2, 0, 0, 0, "t4_b");
        pulse(5, 3, 0, 0, 0, "t4_c");
        exp_q.push_back(20);
        pulse(5, 0, 1, 0, 0, "t4_d");
        pulse(210, 0, 1, 0, 0, "t4_keep");
        pulse(100, 0, 1, 0, 1, "t4_drop");
        step(0, 0, 1, 1, 0, 0, 1, "t4_exit");
        pulse(0, 2, 0, 0, 1, "t4_e");
        pulse(0, 3, 0, 0, 1, "t4_f");
        exp_q.push_back(210);
        pulse(0, 0, 1, 0, 1, "t4_g");
        step(0, 0, 1, 0, 0, 0, 1, "t4_release");
        step(0, 0, 1, 0, 0, 0, 1, "ready_ignored");

        // Exit with pending full and a same-cycle edge: both are folded.
        pulse(1, 1, 0, 0, 1, "fold_a");
        pulse(1, 2, 0, 0, 1, "fold_b");
        pulse(1, 3, 0, 0, 1, "fold_c");
        exp_q.push_back(4);
        pulse(1, 0, 1, 0, 1, "fold_d");
        pulse(7, 0, 1, 0, 1, "fold_pend");
        step(8, 1, 1, 2, 0, 0, 1, "fold_both");
        step(0, 0, 0, 2, 0, 0, 1, "fold_both_low");
        pulse(1, 3, 0, 0, 1, "fold_e");
        exp_q.push_back(17);
        pulse(1, 0, 1, 0, 1, "fold_f");
        // Exit with pending empty and a same-cycle edge.
        step(9, 1, 1, 1, 0, 0, 1, "fold_prod");
        step(0, 0, 0, 1, 0, 0, 1, "fold_prod_low");
        pulse(1, 2, 0, 0, 1, "fold_g");
        pulse(1, 3, 0, 0, 1, "fold_h");
        exp_q.push_back(12);
        pulse(1, 0, 1, 0, 1, "fold_i");
        step(0, 0, 1, 0, 0, 0, 1, "fold_release");

        // Reset in the middle of a partial sum, then a fresh run.
        pulse(50, 1, 0, 0, 1, "t6_a");
        pulse(50, 2, 0, 0, 1, "t6_b");
        a_reset = 1'b1;
        @(posedge clk);
        #1;
        a_reset = 1'b0;
        check("t6_rst_cnt", a_cnt, 0);
        check("t6_rst_sv",  a_sv,  0);
        check("t6_rst_ovf", a_ovf, 0);
        check("t6_rst_ovr", a_ovr, 0);
        pulse(100, 1, 0, 0, 0, "t6_c");
        pulse(100, 2, 0, 0, 0, "t6_d");
        pulse(100, 3, 0, 0, 0, "t6_e");
        exp_q.push_back(400);
        pulse(100, 0, 1, 0, 0, "t6_f");
        step(0, 0, 1, 0, 0, 0, 0, "t6_release");

        // Valid already high when reset releases counts once; level does not recount.
        a_reset = 1'b1;
        a_valid = 1'b1;
        a_product = 33;
        @(posedge clk);
        #1;
        a_reset = 1'b0;
        check("rstv_hold_cnt", a_cnt, 0);
        step(33, 1, 0, 1, 0, 0, 0, "rstv_edge");
        step(33, 1, 0, 1, 0, 0, 0, "rstv_level");
        step(33, 0, 0, 1, 0, 0, 0, "rstv_low");
        a_clear = 1'b1;
        @(posedge clk);
        #1;
        a_clear = 1'b0;
        check("a_clear_cnt", a_cnt, 0);

        // Instance B: 11-bit accumulator saturates at 2047.
        b_product = 961;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1;
            @(posedge clk);
            #1;
            b_valid = 1'b0;
            if (i == 1) check("b_no_ovf_yet", b_ovf, 0);
            @(posedge clk);
            #1;
        end
        check("b_cnt3", b_cnt, 3);
        check("b_ovf", b_ovf, 1);
        check("b_sv0", b_sv, 0);
        b_valid = 1'b1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        check("b_sum_sat", b_sum, 2047);
        check("b_sv1", b_sv, 1);
        b_clear = 1'b1;
        @(posedge clk);
        #1;
        b_clear = 1'b0;
        check("b_clr_sum", b_sum, 0);
        check("b_clr_sv",  b_sv,  0);
        check("b_clr_cnt", b_cnt, 0);
        check("b_clr_ovf", b_ovf, 0);
        check("b_clr_ovr", b_ovr, 0);

        repeat (2) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
